// File: rtl/leaf_user_packetizer_if.sv
// User payload streams in, BFT packet stream out.
// Slave side is the packetizer; master side is the user kernel plus the BFT sink.
interface leaf_user_packetizer_if #(
  parameter int NUM_OUT_PORTS = 2,
  parameter int PAYLOAD_BITS  = 32,
  parameter int PACKET_BITS   = 49
);
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
  logic [PACKET_BITS-1:0]                pkt_out;
  logic                                  pkt_vld;
  logic                                  pkt_rdy;

  modport master (
    output din_leaf_user2interface,
    output vld_user2interface,
    output pkt_rdy,
    input  ack_interface2user,
    input  pkt_out,
    input  pkt_vld
  );

  modport slave (
    input  din_leaf_user2interface,
    input  vld_user2interface,
    input  pkt_rdy,
    output ack_interface2user,
    output pkt_out,
    output pkt_vld
  );
endinterface

// File: rtl/leaf_user_packetizer.sv
// Round-robin packetizer: credit-gated user streams stamped with dest/addr; 1-cycle latency.
// Backpressure: no grant while the output register holds an unaccepted packet.
module leaf_user_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 2,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk_user,
  input  logic                     reset_n,
  leaf_user_packetizer_if.slave    bus,
  input  logic                     cfg_wr_en,
  input  logic [NUM_PORT_BITS-1:0] cfg_port,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
  input  logic                     credit_vld,
  input  logic [NUM_PORT_BITS-1:0] credit_port,
  output logic                     credit_err
);
  localparam int PTR_W  = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int CRED_W = NUM_BRAM_ADDR_BITS + 1;
  localparam int unsigned DEPTH = 32'd1 << NUM_BRAM_ADDR_BITS;

  logic [NUM_OUT_PORTS-1:0] configured;
  logic [NUM_LEAF_BITS-1:0] dest_leaf [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dest_port [NUM_OUT_PORTS];
  logic [CRED_W-1:0]        credit    [NUM_OUT_PORTS];
  logic [CRED_W-1:0]        credit_nxt[NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_ptr  [NUM_OUT_PORTS];
  int unsigned              cred_sum  [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] cred_ovf;
  logic [NUM_OUT_PORTS-1:0] credit_hit;
  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] ack;
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         rr_nxt;
  logic [PTR_W-1:0]         gnt_idx;
  logic                     gnt_found;
  int                       cand;
  logic                     slot_free;
  logic                     cfg_ok;
  logic                     credit_ok;
  logic [PTR_W-1:0]         cfg_idx;
  logic [PTR_W-1:0]         credit_idx;
  logic [PACKET_BITS-1:0]   pkt_q;
  logic                     pkt_vld_q;

  assign slot_free  = !pkt_vld_q || bus.pkt_rdy;
  assign cfg_ok     = cfg_wr_en && (32'(cfg_port) < NUM_OUT_PORTS);
  assign credit_ok  = credit_vld && (32'(credit_port) < NUM_OUT_PORTS);
  assign cfg_idx    = cfg_port[PTR_W-1:0];
  assign credit_idx = credit_port[PTR_W-1:0];

  always_comb begin
    eligible   = '0;
    credit_hit = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i]   = bus.vld_user2interface[i] && configured[i] &&
                      (credit[i] != '0) && slot_free;
      credit_hit[i] = credit_ok && (credit_idx == PTR_W'(i));
    end
  end

  // Search upward from rr_ptr with wrap; the first eligible port wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_OUT_PORTS;
      if (!gnt_found && eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      ack[i] = gnt_found && (gnt_idx == PTR_W'(i));
    end
  end

  assign rr_nxt = (int'(gnt_idx) == NUM_OUT_PORTS - 1) ? '0 : gnt_idx + 1'b1;

  // A grant never hits a zero counter, so the subtraction cannot underflow.
  always_comb begin
    cred_ovf = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      cred_sum[i] = 32'(credit[i])
                  + (credit_hit[i] ? 32'(FREESPACE_UPDATE_SIZE) : 32'd0)
                  - (ack[i] ? 32'd1 : 32'd0);
      if (cred_sum[i] > DEPTH) begin
        credit_nxt[i] = CRED_W'(DEPTH);
        cred_ovf[i]   = 1'b1;
      end else begin
        credit_nxt[i] = cred_sum[i][CRED_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      configured <= '0;
      rr_ptr     <= '0;
      pkt_q      <= '0;
      pkt_vld_q  <= 1'b0;
      credit_err <= 1'b0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        dest_leaf[i] <= '0;
        dest_port[i] <= '0;
        credit[i]    <= CRED_W'(DEPTH);
        addr_ptr[i]  <= '0;
      end
    end else begin
      if (cfg_ok) begin
        dest_leaf[cfg_idx]  <= cfg_dest_leaf;
        dest_port[cfg_idx]  <= cfg_dest_port;
        configured[cfg_idx] <= 1'b1;
      end
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= credit_nxt[i];
      end
      if (|cred_ovf) begin
        credit_err <= 1'b1;
      end
      if (gnt_found) begin
        addr_ptr[gnt_idx] <= addr_ptr[gnt_idx] + 1'b1;
        rr_ptr            <= rr_nxt;
        pkt_q             <= {1'b1, dest_leaf[gnt_idx], dest_port[gnt_idx], addr_ptr[gnt_idx],
                              bus.din_leaf_user2interface[gnt_idx*PAYLOAD_BITS +: PAYLOAD_BITS]};
        pkt_vld_q         <= 1'b1;
      end else if (bus.pkt_rdy) begin
        pkt_vld_q <= 1'b0;
      end
    end
  end

  assign bus.ack_interface2user = ack;
  assign bus.pkt_out            = pkt_q;
  assign bus.pkt_vld            = pkt_vld_q;
endmodule

// File: tb/tb_leaf_user_packetizer.sv
// Directed bench for leaf_user_packetizer: vector table plus hand-built credit/reset sequences.
module tb_leaf_user_packetizer;
  logic       clk_user = 1'b0;
  logic       reset_n  = 1'b0;
  logic       cfg_wr_en = 1'b0;
  logic [3:0] cfg_port = '0;
  logic [4:0] cfg_dest_leaf = '0;
  logic [3:0] cfg_dest_port = '0;
  logic       credit_vld = 1'b0;
  logic [3:0] credit_port = '0;
  logic       credit_err;

  int n_pass  = 0;
  int n_total = 0;

  leaf_user_packetizer_if u_if ();

  leaf_user_packetizer dut (
    .clk_user      (clk_user),
    .reset_n       (reset_n),
    .bus           (u_if),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_port      (cfg_port),
    .cfg_dest_leaf (cfg_dest_leaf),
    .cfg_dest_port (cfg_dest_port),
    .credit_vld    (credit_vld),
    .credit_port   (credit_port),
    .credit_err    (credit_err)
  );

  always #5 clk_user = ~clk_user;

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        rdy;
    logic [1:0]  ack;
    logic        pv;
    logic [48:0] pkt;
  } vec_t;

  vec_t tv [19];

  function automatic logic [48:0] pk(input logic [4:0] l, input logic [3:0] p,
                                     input logic [6:0] a, input logic [31:0] d);
    return {1'b1, l, p, a, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_user);
    #1;
  endtask

  task automatic cfg(input logic [3:0] p, input logic [4:0] l, input logic [3:0] dp);
    cfg_wr_en = 1'b1; cfg_port = p; cfg_dest_leaf = l; cfg_dest_port = dp;
    step();
    cfg_wr_en = 1'b0;
  endtask

  // Hold one port valid for a fixed number of cycles and count its acks.
  task automatic drain(input int p, input int cycles, output int acks, output logic [6:0] last_addr);
    acks = 0;
    last_addr = '0;
    u_if.pkt_rdy = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      u_if.vld_user2interface = 2'b01 << p;
      u_if.din_leaf_user2interface = {32'(c) | 32'h1000_0000, 32'(c)};
      @(negedge clk_user);
      if (u_if.ack_interface2user[p]) acks++;
      if (u_if.pkt_vld) last_addr = u_if.pkt_out[38:32];
      step();
    end
    u_if.vld_user2interface = '0;
  endtask

  int         acks;
  logic [6:0] last_addr;

  initial begin
    u_if.vld_user2interface = '0;
    u_if.din_leaf_user2interface = '0;
    u_if.pkt_rdy = 1'b1;

    tv[0]  = '{2'b01, 32'hDEADBEEF, 32'h0,   1'b1, 2'b01, 1'b0, 49'h0};
    tv[1]  = '{2'b01, 32'hCAFEF00D, 32'h0,   1'b1, 2'b01, 1'b1, pk(3, 1, 0, 32'hDEADBEEF)};
    tv[2]  = '{2'b00, 32'h0,        32'h0,   1'b1, 2'b00, 1'b1, pk(3, 1, 1, 32'hCAFEF00D)};
    tv[3]  = '{2'b11, 32'hA0,       32'hB0,  1'b1, 2'b10, 1'b0, 49'h0};
    tv[4]  = '{2'b11, 32'hA1,       32'hB1,  1'b1, 2'b01, 1'b1, pk(6, 2, 0, 32'hB0)};
    tv[5]  = '{2'b11, 32'hA2,       32'hB2,  1'b1, 2'b10, 1'b1, pk(3, 1, 2, 32'hA1)};
    tv[6]  = '{2'b11, 32'hA3,       32'hB3,  1'b1, 2'b01, 1'b1, pk(6, 2, 1, 32'hB2)};
    tv[7]  = '{2'b00, 32'h0,        32'h0,   1'b1, 2'b00, 1'b1, pk(3, 1, 3, 32'hA3)};
    tv[8]  = '{2'b00, 32'h0,        32'h0,   1'b1, 2'b00, 1'b0, 49'h0};
    tv[9]  = '{2'b11, 32'hC0,       32'hD0,  1'b0, 2'b10, 1'b0, 49'h0};
    for (int i = 10; i < 15; i++)
      tv[i] = '{2'b11, 32'hC0,      32'hD0,  1'b0, 2'b00, 1'b1, pk(6, 2, 2, 32'hD0)};
    tv[15] = '{2'b11, 32'hC0,       32'hD1,  1'b1, 2'b01, 1'b1, pk(6, 2, 2, 32'hD0)};
    tv[16] = '{2'b11, 32'hC1,       32'hD1,  1'b1, 2'b10, 1'b1, pk(3, 1, 4, 32'hC0)};
    tv[17] = '{2'b00, 32'h0,        32'h0,   1'b1, 2'b00, 1'b1, pk(6, 2, 3, 32'hD1)};
    tv[18] = '{2'b00, 32'h0,        32'h0,   1'b1, 2'b00, 1'b0, 49'h0};

    #23 reset_n = 1'b1;
    step();
    @(negedge clk_user);
    check("rst_pkt_vld", 64'(u_if.pkt_vld), 64'd0);
    check("rst_pkt_out", 64'(u_if.pkt_out), 64'd0);
    check("rst_ack", 64'(u_if.ack_interface2user), 64'd0);
    check("rst_credit_err", 64'(credit_err), 64'd0);
    step();

    // Unconfigured port must never be acked.
    for (int c = 0; c < 3; c++) begin
      u_if.vld_user2interface = 2'b01;
      u_if.din_leaf_user2interface = {32'h0, 32'h1111_1111};
      @(negedge clk_user);
      check($sformatf("unconf_ack_c%0d", c), 64'(u_if.ack_interface2user), 64'd0);
      step();
    end
    u_if.vld_user2interface = '0;

    cfg(4'd0, 5'd3, 4'd1);
    cfg(4'd2, 5'd31, 4'd15);
    cfg(4'd1, 5'd6, 4'd2);

    for (int i = 0; i < 19; i++) begin
      u_if.vld_user2interface = tv[i].vld;
      u_if.din_leaf_user2interface = {tv[i].d1, tv[i].d0};
      u_if.pkt_rdy = tv[i].rdy;
      @(negedge clk_user);
      check($sformatf("vec%0d_ack", i), 64'(u_if.ack_interface2user), 64'(tv[i].ack));
      check($sformatf("vec%0d_pkt_vld", i), 64'(u_if.pkt_vld), 64'(tv[i].pv));
      if (tv[i].pv) check($sformatf("vec%0d_pkt_out", i), 64'(u_if.pkt_out), 64'(tv[i].pkt));
      step();
    end

    // Reset while a packet is in flight.
    u_if.vld_user2interface = 2'b01;
    u_if.din_leaf_user2interface = {32'h0, 32'h5555_AAAA};
    @(negedge clk_user);
    check("pre_rst_ack", 64'(u_if.ack_interface2user), 64'd1);
    step();
    #2;
    check("pre_rst_pkt_vld", 64'(u_if.pkt_vld), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_pkt_vld", 64'(u_if.pkt_vld), 64'd0);
    check("midrst_ack", 64'(u_if.ack_interface2user), 64'd0);
    @(negedge clk_user);
    reset_n = 1'b1;
    step();
    @(negedge clk_user);
    check("postrst_unconf_ack", 64'(u_if.ack_interface2user), 64'd0);
    step();
    u_if.vld_user2interface = '0;

    cfg(4'd0, 5'd3, 4'd1);
    cfg(4'd1, 5'd6, 4'd2);

    // Out-of-range credit port must be ignored, then overflow port1 at full credit.
    credit_vld = 1'b1; credit_port = 4'd2;
    step();
    credit_vld = 1'b0;
    @(negedge clk_user);
    check("credit_oob_err", 64'(credit_err), 64'd0);
    step();
    credit_vld = 1'b1; credit_port = 4'd1;
    step();
    credit_vld = 1'b0;
    @(negedge clk_user);
    check("credit_ovf_err", 64'(credit_err), 64'd1);
    step();

    drain(0, 132, acks, last_addr);
    check("p0_exhaust_acks", 64'(acks), 64'd128);
    check("p0_last_addr", 64'(last_addr), 64'd127);

    u_if.vld_user2interface = 2'b01;
    credit_vld = 1'b1; credit_port = 4'd0;
    @(negedge clk_user);
    check("p0_stall_ack", 64'(u_if.ack_interface2user), 64'd0);
    step();
    credit_vld = 1'b0;
    @(negedge clk_user);
    check("p0_resume_ack", 64'(u_if.ack_interface2user), 64'd1);
    step();
    u_if.vld_user2interface = '0;
    @(negedge clk_user);
    check("p0_resume_pkt_vld", 64'(u_if.pkt_vld), 64'd1);
    check("p0_wrap_addr", 64'(u_if.pkt_out[38:32]), 64'd0);
    step();

    // 63 credits left; spend 53 to reach 10, then grant and credit together.
    drain(0, 53, acks, last_addr);
    check("p0_to10_acks", 64'(acks), 64'd53);
    u_if.vld_user2interface = 2'b01;
    credit_vld = 1'b1; credit_port = 4'd0;
    @(negedge clk_user);
    check("p0_simul_ack", 64'(u_if.ack_interface2user), 64'd1);
    step();
    credit_vld = 1'b0;
    u_if.vld_user2interface = '0;
    drain(0, 80, acks, last_addr);
    check("p0_after_simul_acks", 64'(acks), 64'd73);

    drain(1, 132, acks, last_addr);
    check("p1_saturated_acks", 64'(acks), 64'd128);
    check("credit_err_sticky", 64'(credit_err), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
